// File: rtl/handshake_pkg.sv
// Shared types for the dav_/rfd handshake consumer.
// STAR state encodings and width helpers.
package handshake_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_ACK  = 2'd1,
    S_DONE = 2'd2
  } star_t;

  // Sum width wide enough for k words of n bits.
  function automatic int sum_width(int n, int k);
    return n + $clog2(k);
  endfunction

  // Counter width able to hold the value k.
  function automatic int count_width(int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/dav_synchronizer.sv
// Two-flop synchronizer for an active-low dav_ strobe.
// Flops reset to 1 (no data valid).
module dav_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic dav_in_,
  output logic dav_sync_
);

  logic meta_;

  // Two-stage shift toward the clock domain of the consumer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_     <= 1'b1;
      dav_sync_ <= 1'b1;
    end else begin
      meta_     <= dav_in_;
      dav_sync_ <= meta_;
    end
  end

endmodule

// File: rtl/handshake_consumer.sv
// Consumer end of the dav_/rfd handshake; sums K words per block.
// Optional macro HANDSHAKE_CONSUMER_DAV_SYNC_EN adds a dav_ synchronizer.
module handshake_consumer
  import handshake_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               data,
  input  logic                       dav_,
  output logic                       rfd,
  output logic [sum_width(N,K)-1:0]  sum,
  output logic                       done
);

  localparam int SW = sum_width(N, K);
  localparam int CW = count_width(K);
  localparam logic [CW-1:0] KC = CW'(K);

  star_t         state;
  star_t         nxt;
  logic [CW-1:0] count;
  logic          dav_s;

`ifdef HANDSHAKE_CONSUMER_DAV_SYNC_EN
  dav_synchronizer u_sync (
    .clock     (clock),
    .reset     (reset),
    .dav_in_   (dav_),
    .dav_sync_ (dav_s)
  );
`else
  assign dav_s = dav_;
`endif

  // STAR state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_WAIT;
    else       state <= nxt;
  end

  // STAR next-state logic.
  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT: if (!dav_s) nxt = S_ACK;
      S_ACK: begin
        if (dav_s) nxt = (count == KC) ? S_DONE : S_WAIT;
      end
      S_DONE: nxt = S_WAIT;
      default: nxt = S_WAIT;
    endcase
  end

  // Moore outputs decoded from the STAR register.
  always_comb begin
    rfd  = (state == S_WAIT);
    done = (state == S_DONE);
  end

  // Accumulator and word counter; first word of a block overwrites sum.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum   <= '0;
      count <= '0;
    end else if (state == S_WAIT && !dav_s) begin
      count <= count + CW'(1);
      if (count == '0) sum <= SW'(data);
      else             sum <= sum + SW'(data);
    end else if (state == S_DONE) begin
      count <= '0;
    end
  end

endmodule

// File: tb/tb_handshake_consumer.sv
// Randomized self-checking bench for handshake_consumer.
// Reference: running block sum of words handed over, done after K-th word.
module tb_handshake_consumer;

`ifdef HANDSHAKE_CONSUMER_DAV_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data  = 8'd0;
  logic       dav_  = 1'b1;
  logic       sel   = 1'b0;

  logic       rfd4, done4, rfd1, done1;
  logic [9:0] sum4;
  logic [7:0] sum1;
  logic       dav4_, dav1_;

  logic       rfd_m, done_m;
  logic [9:0] sum_m;
  int         kk;

  int tests = 0;
  int fails = 0;

  int nw   = 0;
  int expv = 0;

  always #5 clock = ~clock;

  assign dav4_  = sel ? 1'b1 : dav_;
  assign dav1_  = sel ? dav_ : 1'b1;
  assign rfd_m  = sel ? rfd1 : rfd4;
  assign done_m = sel ? done1 : done4;
  assign sum_m  = sel ? {2'b00, sum1} : sum4;
  assign kk     = sel ? 1 : 4;

  handshake_consumer #(.N(8), .K(4)) u4 (
    .clock (clock),
    .reset (reset),
    .data  (data),
    .dav_  (dav4_),
    .rfd   (rfd4),
    .sum   (sum4),
    .done  (done4)
  );

  handshake_consumer #(.N(8), .K(1)) u1 (
    .clock (clock),
    .reset (reset),
    .data  (data),
    .dav_  (dav1_),
    .rfd   (rfd1),
    .sum   (sum1),
    .done  (done1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    if (obs != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input int hold,
                           input logic [7:0] alt);
    int t = 0;
    while (!rfd_m && t < 20) begin
      @(negedge clock);
      t++;
    end
    if (t >= 20) chk("rfd_wait_timeout", 0, 1);
    if (nw == 0) expv = w;
    else         expv = expv + w;
    nw++;
    data = w;
    dav_ = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clock);
      chk("rfd_pre_accept", rfd_m, 1);
    end
    @(negedge clock);
    chk("rfd_accept", rfd_m, 0);
    chk("sum_accept", sum_m, expv);
    chk("done_accept", done_m, 0);
    for (int i = 0; i < hold; i++) begin
      data = alt;
      @(negedge clock);
      chk("rfd_hold", rfd_m, 0);
    end
    dav_ = 1'b1;
    data = $urandom;
    for (int i = 0; i < LAT; i++) begin
      @(negedge clock);
      chk("rfd_pre_release", rfd_m, 0);
      chk("done_pre_release", done_m, 0);
    end
    @(negedge clock);
    if (nw == kk) begin
      chk("done_pulse", done_m, 1);
      chk("rfd_in_done", rfd_m, 0);
      chk("sum_block", sum_m, expv);
      @(negedge clock);
      chk("done_end", done_m, 0);
      chk("rfd_after_done", rfd_m, 1);
      chk("sum_hold", sum_m, expv);
      nw = 0;
    end else begin
      chk("rfd_release", rfd_m, 1);
      chk("done_idle", done_m, 0);
      chk("sum_partial", sum_m, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_rfd4", rfd4, 1);
    chk("rst_sum4", sum4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_rfd1", rfd1, 1);
    chk("rst_sum1", sum1, 0);
    nw = 0;
    expv = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    do_reset();

    sel = 1'b0;
    send_word(8'd10, 0, 8'd10);
    send_word(8'd20, 0, 8'd20);
    send_word(8'd30, 0, 8'd30);
    send_word(8'd40, 0, 8'd40);
    chk("blk_100", sum_m, 100);

    for (int i = 0; i < 4; i++) send_word(8'd255, 0, 8'd255);
    chk("blk_1020", sum_m, 1020);

    send_word(8'd7, 5, 8'd9);
    chk("hold_once", sum_m, 7);
    send_word(8'd1, 0, 8'd1);
    send_word(8'd1, 0, 8'd1);
    send_word(8'd1, 0, 8'd1);
    chk("hold_blk", sum_m, 10);

    send_word(8'd5, 0, 8'd5);
    send_word(8'd6, 1, 8'd6);
    do_reset();
    send_word(8'd1, 0, 8'd1);
    send_word(8'd2, 0, 8'd2);
    send_word(8'd3, 0, 8'd3);
    send_word(8'd4, 0, 8'd4);
    chk("blk_after_rst", sum_m, 10);

    for (int i = 0; i < 32; i++) begin
      w = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      send_word(w, $urandom_range(0, 3), 8'($urandom));
    end

    @(negedge clock);
    sel = 1'b1;
    nw = 0;
    send_word(8'd3, 0, 8'd3);
    chk("k1_first", sum_m, 3);
    send_word(8'd4, 2, 8'd8);
    chk("k1_second", sum_m, 4);
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      send_word(w, $urandom_range(0, 2), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
